// File: rtl/fetch_pkg.sv
// Shared state encoding and PC/jump-field constants for the fetch sequencer.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_HOLD,
        ST_ERROR
    } fetch_state_e;

    localparam logic [31:0] PC_INCR    = 32'd4;
    localparam int unsigned JUMP_IDX_W = 26;
    localparam int unsigned JUMP_HI_W  = 4;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC target mux: sequential, taken branch, or jump (jump wins).
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [31:0]           pc_i,
    input  logic [JUMP_IDX_W-1:0] jump_idx_i,
    input  logic                  jump_i,
    input  logic                  branch_i,
    input  logic                  alu_zero_i,
    input  logic [31:0]           branch_imm_i,
    output logic [31:0]           next_pc_o
);

    logic [31:0] p4;

    always_comb begin
        p4        = pc_i + PC_INCR;
        next_pc_o = p4;
        if (jump_i) begin
            next_pc_o = {p4[31:32-JUMP_HI_W], jump_idx_i, 2'b00};
        end else if (branch_i && alu_zero_i) begin
            next_pc_o = p4 + (branch_imm_i << 2);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// PC-owning fetch FSM: req/ack instruction memory side, valid/ready decode side, flush redirect.
// Optional fetch watchdog and ERROR state enabled by defining FETCH_TIMEOUT_EN.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        branch,
    input  logic        alu_zero,
    input  logic [31:0] branch_imm,
    input  logic        jump,
    input  logic        flush,
    input  logic [31:0] flush_target,
    output logic        fetch_error
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  req_addr_q;
    logic         imem_req_q;
    logic         instr_valid_q;
    logic [31:0]  instr_q;
    logic [31:0]  instr_pc_q;
    logic [31:0]  next_pc_d;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q;
    logic             fetch_error_q;
`endif

    next_pc_calc u_next_pc (
        .pc_i         (instr_pc_q),
        .jump_idx_i   (instr_q[JUMP_IDX_W-1:0]),
        .jump_i       (jump),
        .branch_i     (branch),
        .alu_zero_i   (alu_zero),
        .branch_imm_i (branch_imm),
        .next_pc_o    (next_pc_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            req_addr_q    <= RESET_PC;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q         <= '0;
            fetch_error_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q    <= ST_FETCH;
                    imem_req_q <= 1'b1;
                    if (flush) begin
                        pc_q       <= flush_target;
                        req_addr_q <= flush_target;
                    end else begin
                        req_addr_q <= pc_q;
                    end
`ifdef FETCH_TIMEOUT_EN
                    cnt_q <= '0;
`endif
                end
                ST_FETCH: begin
                    // Flush with ack discards the word and reissues at the target in place.
                    if (imem_ack && flush) begin
                        pc_q       <= flush_target;
                        req_addr_q <= flush_target;
`ifdef FETCH_TIMEOUT_EN
                        cnt_q <= '0;
`endif
                    end else if (imem_ack) begin
                        instr_q       <= imem_rdata;
                        instr_pc_q    <= req_addr_q;
                        state_q       <= ST_HOLD;
                        imem_req_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                    end else if (flush) begin
                        pc_q    <= flush_target;
                        state_q <= ST_DRAIN;
`ifdef FETCH_TIMEOUT_EN
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q       <= ST_ERROR;
                        imem_req_q    <= 1'b0;
                        fetch_error_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                ST_DRAIN: begin
                    if (flush) begin
                        pc_q <= flush_target;
                    end
                    if (imem_ack) begin
                        state_q    <= ST_FETCH;
                        req_addr_q <= flush ? flush_target : pc_q;
`ifdef FETCH_TIMEOUT_EN
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q       <= ST_ERROR;
                        imem_req_q    <= 1'b0;
                        fetch_error_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                ST_HOLD: begin
                    if (flush) begin
                        pc_q          <= flush_target;
                        req_addr_q    <= flush_target;
                        state_q       <= ST_FETCH;
                        imem_req_q    <= 1'b1;
                        instr_valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
                        cnt_q <= '0;
`endif
                    end else if (instr_ready) begin
                        pc_q          <= next_pc_d;
                        req_addr_q    <= next_pc_d;
                        state_q       <= ST_FETCH;
                        imem_req_q    <= 1'b1;
                        instr_valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
                        cnt_q <= '0;
`endif
                    end
                end
`ifdef FETCH_TIMEOUT_EN
                ST_ERROR: begin
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
`endif
                default: begin
                    state_q       <= ST_IDLE;
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = req_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_error = fetch_error_q;
`else
    assign fetch_error = 1'b0;
`endif

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control FSM that owns the program counter and sequences instruction fetches from a variable-latency instruction memory over a req/ack handshake.
- Presents one fetched instruction at a time to decode over a valid/ready handshake.
- Computes the next PC (sequential, branch, jump) when decode consumes the instruction.
- Accepts an asynchronous-to-pipeline flush/redirect, which is honoured even while a fetch is outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, watchdog limit in cycles for an outstanding fetch; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- imem_req  out  1  fetch request; held high until imem_ack
- imem_addr  out  32  fetch address; stable while imem_req=1
- imem_ack  in  1  single-cycle response strobe
- imem_rdata  in  32  instruction word; valid when imem_ack=1
- instr_valid  out  1  held instruction available to decode
- instr  out  32  held instruction word
- instr_pc  out  32  address of held instruction
- instr_ready  in  1  decode consumes the held instruction this cycle
- branch  in  1  held instruction is a branch (sampled on consume)
- alu_zero  in  1  branch condition (sampled on consume)
- branch_imm  in  32  sign-extended word offset (sampled on consume)
- jump  in  1  held instruction is a jump (sampled on consume)
- flush  in  1  redirect request
- flush_target  in  32  redirect address
- fetch_error  out  1  sticky timeout flag; constant 0 without FETCH_TIMEOUT_EN

Behaviour:
- States: IDLE, FETCH, DRAIN, HOLD, ERROR (ERROR exists only with the macro).
- Reset values: state=IDLE, pc=RESET_PC, req_addr=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, fetch_error=0.
- Output decode:
  - imem_req=1 in FETCH and DRAIN.
  - imem_addr = req_addr, latched from pc on entry to FETCH.
  - instr_valid=1 only in HOLD.
- IDLE:
  - Next cycle go to FETCH.
  - If flush=1, pc<=flush_target first.
- FETCH:
  - On imem_ack: instr<=imem_rdata, instr_pc<=req_addr, go to HOLD. Ack-to-valid latency is 1 cycle.
  - On flush without ack: pc<=flush_target, go to DRAIN. The request stays asserted with the old address, per protocol.
  - On flush together with ack: response is discarded, pc<=flush_target, req_addr<=flush_target, stay in FETCH. The new request is visible the next cycle.
- DRAIN:
  - Wait for imem_ack and discard the data; then req_addr<=pc and go to FETCH.
  - A further flush in DRAIN overwrites pc (last flush wins).
- HOLD:
  - instr_valid=1 with instr and instr_pc stable until consumed.
  - On instr_ready without flush: pc<=next_pc, req_addr<=next_pc, go to FETCH.
  - On flush (priority over instr_ready): instruction is dropped, pc<=flush_target, go to FETCH.
- next_pc, with p4 = instr_pc+4, modulo 2^32:
  - If jump=1: {p4[31:28], instr[25:0], 2'b00}.
  - Else if branch & alu_zero: p4 + (branch_imm<<2), truncated to 32 bits.
  - Else: p4.
  - jump has priority over branch.
- Wrap-around: PC 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no error.
- Reset asserted mid-fetch:
  - State returns to IDLE immediately (asynchronous).
  - A late imem_ack arriving while in IDLE is ignored.
- imem_ack in HOLD or IDLE is a protocol violation and is ignored.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to FETCH/DRAIN and increments each cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES, go to ERROR. fetch_error<=1 (sticky until reset), imem_req=0, instr_valid=0.
  - Flush is ignored in ERROR. Only reset exits ERROR.
- When undefined: no counter, fetch_error tied to 0, FETCH/DRAIN wait indefinitely.

Decomposition:
- Shared package (fetch_pkg):
  - State encoding typedef (IDLE/FETCH/DRAIN/HOLD/ERROR).
  - PC_INCR=4.
  - Jump field widths (index 26, upper bits 4).
- One natural sub-module, next_pc_calc: combinational target mux (sequential/branch/jump) reusable by future pipelined fetch.

Test Plan:
- Reset with RESET_PC=0, memory acks after 2 cycles, instr_ready=1 -> imem_addr sequence 0x0,0x4,0x8; instr_pc matches; instr_valid pulses once per fetch.
- HOLD, instr_pc=0x100, branch=1, alu_zero=1, branch_imm=0xFFFF_FFFE -> next imem_addr=0x0FC. Same with alu_zero=0 -> 0x104.
- HOLD, instr_pc=0x1000_0000, instr=0x0800_0040, jump=1, branch=1, alu_zero=1 -> next imem_addr=0x1000_0100 (jump wins).
- Flush(target 0x200) while FETCH at 0x40 with ack 3 cycles later -> imem_addr stays 0x40 until ack, data discarded, instr_valid stays 0, next request at 0x200.
- flush and imem_ack in same cycle, and flush with instr_ready in HOLD -> no instr_valid for the dropped word; next imem_addr=flush_target.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack never arrives -> fetch_error=1 after 16 cycles, imem_req=0, flush ignored; reset clears fetch_error and restarts fetch at RESET_PC.
